// File: rtl/layer_pkg.sv
// Shared types and helpers for the layer_* pipeline stages.
package layer_pkg;

    typedef enum logic [0:0] {ST_ACC, ST_OUT} argmax_state_t;

    // Width needed to hold any value 0..n.
    function automatic int clog2_plus1(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Running-maximum select: keeps the current best unless the new element is strictly larger.
module argmax_cmp #(
    parameter int T    = 9,
    parameter int LOGM = 3
) (
    input  logic signed [T-1:0]    cur_val,
    input  logic        [LOGM-1:0] cur_idx,
    input  logic signed [T-1:0]    new_val,
    input  logic        [LOGM-1:0] new_idx,
    input  logic                   first,
    output logic signed [T-1:0]    nxt_val,
    output logic        [LOGM-1:0] nxt_idx
);

    // Strict compare so that ties keep the earlier (lower) index.
    always_comb begin
        if (first || (new_val > cur_val)) begin
            nxt_val = new_val;
            nxt_idx = new_idx;
        end else begin
            nxt_val = cur_val;
            nxt_idx = cur_idx;
        end
    end

endmodule

// File: rtl/layer_argmax.sv
// Streaming arg-max over one M-element signed vector; emits the winning index.
// Optional max_out port is enabled by defining LAYER_ARGMAX_MAXVAL_EN.
module layer_argmax
    import layer_pkg::*;
#(
    parameter int M    = 5,
    parameter int T    = 9,
    parameter int LOGM = clog2_plus1(M)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic signed [T-1:0]    data_in,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic        [LOGM-1:0] data_out
`ifdef LAYER_ARGMAX_MAXVAL_EN
    ,
    output logic signed [T-1:0]    max_out
`endif
);

    localparam logic [LOGM-1:0] LAST_IDX = LOGM'(M - 1);

    argmax_state_t          state_q, state_d;
    logic [LOGM-1:0]        count_q;
    logic [LOGM-1:0]        best_idx_q;
    logic signed [T-1:0]    best_val_q;
    logic [LOGM-1:0]        nxt_idx;
    logic signed [T-1:0]    nxt_val;
    logic                   accept;
    logic                   last;

    assign accept = s_valid && s_ready;
    assign last   = (count_q == LAST_IDX);

    argmax_cmp #(.T(T), .LOGM(LOGM)) u_cmp (
        .cur_val (best_val_q),
        .cur_idx (best_idx_q),
        .new_val (data_in),
        .new_idx (count_q),
        .first   (count_q == '0),
        .nxt_val (nxt_val),
        .nxt_idx (nxt_idx)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_ACC;
        else        state_q <= state_d;
    end

    // NOTE: default assignment first so no path through always_comb can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC:  if (accept && last) state_d = ST_OUT;
            ST_OUT:  if (m_ready)        state_d = ST_ACC;
            default: state_d = ST_ACC;
        endcase
    end

    // s_ready is gated by reset so nothing is consumed while reset is held.
    always_comb begin
        s_ready = reset && (state_q == ST_ACC);
        m_valid = (state_q == ST_OUT);
    end

    // Best registers hold through OUT because no word is accepted there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
        end else if (accept) begin
            best_val_q <= nxt_val;
            best_idx_q <= nxt_idx;
            count_q    <= last ? '0 : count_q + LOGM'(1);
        end
    end

    assign data_out = best_idx_q;
`ifdef LAYER_ARGMAX_MAXVAL_EN
    assign max_out  = best_val_q;
`endif

endmodule

// File: tb/tb_layer_argmax.sv
// Scoreboard bench for layer_argmax (M=5, T=9); max_out checks only with LAYER_ARGMAX_MAXVAL_EN.
module tb_layer_argmax;
    import layer_pkg::*;

    localparam int M    = 5;
    localparam int T    = 9;
    localparam int LOGM = clog2_plus1(M);

    typedef logic signed [T-1:0] elem_t;
    typedef struct {
        logic [LOGM-1:0] idx;
        elem_t           val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, errors = 0, tx_count = 0, rx_count = 0;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    elem_t           data_in = '0;
    logic            m_valid;
    logic            m_ready;
    logic [LOGM-1:0] data_out;
    bit              rand_mode = 1'b0;
    logic            m_ready_dir = 1'b1;
    logic            m_ready_rnd = 1'b1;
`ifdef LAYER_ARGMAX_MAXVAL_EN
    elem_t           max_out;
`endif

    assign m_ready = rand_mode ? m_ready_rnd : m_ready_dir;

    layer_argmax #(.M(M), .T(T)) dut (
        .clk      (clk),
        .reset    (reset),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .data_in  (data_in),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .data_out (data_out)
`ifdef LAYER_ARGMAX_MAXVAL_EN
        ,
        .max_out  (max_out)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        m_ready_rnd = ($urandom_range(0, 3) != 0);
    end

    // Result monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (reset && m_valid && m_ready) begin
            rx_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL result_unexpected: got index %0d with empty scoreboard", data_out);
            end else begin
                e = exp_q.pop_front();
                if (data_out !== e.idx) begin
                    errors++;
                    $display("FAIL result_index: got %0d expected %0d", data_out, e.idx);
                end
`ifdef LAYER_ARGMAX_MAXVAL_EN
                checks++;
                if (max_out !== e.val) begin
                    errors++;
                    $display("FAIL result_max: got %0d expected %0d", max_out, e.val);
                end
`endif
            end
        end
    end

    task automatic push_expected(input elem_t v[M]);
        exp_t e;
        e.idx = '0;
        e.val = v[0];
        for (int i = 1; i < M; i++) begin
            if (v[i] > e.val) begin
                e.val = v[i];
                e.idx = LOGM'(i);
            end
        end
        exp_q.push_back(e);
        tx_count++;
    endtask

    // Called at posedge+1; returns at posedge+1 after the word is taken.
    task automatic send_word(input elem_t v);
        s_valid = 1'b1;
        data_in = v;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                s_valid = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        s_valid = 1'b0;
        $display("FAIL send_timeout: word %0d never accepted", v);
    endtask

    task automatic send_vector(input elem_t v[M], input int max_gap);
        push_expected(v);
        for (int i = 0; i < M; i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
            send_word(v[i]);
        end
    endtask

    task automatic drain(input int budget);
        for (int n = 0; n < budget && exp_q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding", exp_q.size());
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0 || data_out !== '0) begin
            errors++;
            $display("FAIL reset_state: s_ready=%b m_valid=%b data_out=%0d expected 0 0 0", s_ready, m_valid, data_out);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: s_ready=%b m_valid=%b expected 1 0", s_ready, m_valid);
        end
    endtask

    task automatic test_latency();
        elem_t v[M];
        v = '{9'sd3, -9'sd2, 9'sd7, 9'sd1, 9'sd0};
        push_expected(v);
        for (int i = 0; i < M - 1; i++) send_word(v[i]);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: m_valid=%b before last word expected 0", m_valid);
        end
        send_word(v[M-1]);
        checks++;
        if (m_valid !== 1'b1 || s_ready !== 1'b0 || data_out !== 3'd2) begin
            errors++;
            $display("FAIL latency_out: m_valid=%b s_ready=%b data_out=%0d expected 1 0 2", m_valid, s_ready, data_out);
        end
    endtask

    task automatic test_back_to_back();
        elem_t v[M];
        v = '{9'sd4, 9'sd9, 9'sd9, -9'sd1, 9'sd9};
        send_vector(v, 0);
        v = '{-9'sd5, -9'sd3, -9'sd8, -9'sd3, -9'sd100};
        send_vector(v, 0);
        drain(20);
    endtask

    task automatic test_hold();
        elem_t v[M];
        v = '{9'sd1, 9'sd2, 9'sd3, 9'sd4, 9'sd5};
        m_ready_dir = 1'b0;
        send_vector(v, 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || data_out !== 3'd4 || s_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: m_valid=%b data_out=%0d s_ready=%b expected 1 4 0", c, m_valid, data_out, s_ready);
            end
`ifdef LAYER_ARGMAX_MAXVAL_EN
            checks++;
            if (max_out !== 9'sd5) begin
                errors++;
                $display("FAIL hold_max%0d: got %0d expected 5", c, max_out);
            end
`endif
        end
        @(posedge clk);
        #1;
        m_ready_dir = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: m_valid=%b s_ready=%b expected 0 1", m_valid, s_ready);
        end
        drain(5);
    endtask

    task automatic test_mid_reset();
        elem_t v[M];
        send_word(9'sd0);
        send_word(9'sd6);
        send_word(9'sd2);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b0 || data_out !== '0) begin
            errors++;
            $display("FAIL mid_reset_clear: m_valid=%b s_ready=%b data_out=%0d expected 0 0 0", m_valid, s_ready, data_out);
        end
`ifdef LAYER_ARGMAX_MAXVAL_EN
        checks++;
        if (max_out !== '0) begin
            errors++;
            $display("FAIL mid_reset_max: got %0d expected 0", max_out);
        end
`endif
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        v = '{9'sd0, 9'sd0, 9'sd0, 9'sd0, 9'sd1};
        send_vector(v, 0);
        drain(10);
    endtask

    task automatic test_random();
        elem_t v[M];
        rand_mode = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < M; i++) begin
                if ($urandom_range(0, 3) == 0) v[i] = elem_t'(int'($urandom_range(0, 4)) - 2);
                else                           v[i] = elem_t'($urandom_range(0, 511));
            end
            send_vector(v, 2);
        end
        drain(200);
        rand_mode = 1'b0;
        checks++;
        if (rx_count !== tx_count) begin
            errors++;
            $display("FAIL vector_count: received %0d expected %0d", rx_count, tx_count);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_hold();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
